// File: rtl/bpi_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bpi_cmd_sequencer_if
//  Description : Signal bundle between the VME/configuration request side,
//                the command sequencer and the BPI bus interface.
//                Modport "slave" is the sequencer's own view: it accepts
//                requests and drives the bus-interface controls.
//                Modport "master" is the surrounding logic: the requester
//                plus the bus interface that executes single bus cycles.
//  Ports       : REQ/REQ_OP/REQ_ADDR/REQ_DATA   request from host
//                ACK/CTRL_BUSY/DONE/ERROR       request handshake/status
//                RD_DATA/SR                     last read word / status reg
//                BPI_ADDR/BPI_CMD_DATA/BPI_OP   bus cycle description
//                BPI_EXECUTE                    bus cycle start pulse
//                BPI_BUSY/BPI_LOAD_DATA/
//                BPI_DATA_IN                    bus interface responses
//  Revision    : 1.0  initial release
// ============================================================================
interface bpi_cmd_sequencer_if;
    logic        REQ;
    logic [2:0]  REQ_OP;
    logic [22:0] REQ_ADDR;
    logic [15:0] REQ_DATA;
    logic        ACK;
    logic        CTRL_BUSY;
    logic        DONE;
    logic        ERROR;
    logic [15:0] RD_DATA;
    logic [7:0]  SR;
    logic [22:0] BPI_ADDR;
    logic [15:0] BPI_CMD_DATA;
    logic [1:0]  BPI_OP;
    logic        BPI_EXECUTE;
    logic        BPI_BUSY;
    logic        BPI_LOAD_DATA;
    logic [15:0] BPI_DATA_IN;

    modport slave (
        input  REQ, REQ_OP, REQ_ADDR, REQ_DATA,
        input  BPI_BUSY, BPI_LOAD_DATA, BPI_DATA_IN,
        output ACK, CTRL_BUSY, DONE, ERROR, RD_DATA, SR,
        output BPI_ADDR, BPI_CMD_DATA, BPI_OP, BPI_EXECUTE
    );

    modport master (
        output REQ, REQ_OP, REQ_ADDR, REQ_DATA,
        output BPI_BUSY, BPI_LOAD_DATA, BPI_DATA_IN,
        input  ACK, CTRL_BUSY, DONE, ERROR, RD_DATA, SR,
        input  BPI_ADDR, BPI_CMD_DATA, BPI_OP, BPI_EXECUTE
    );
endinterface
`default_nettype wire

// File: rtl/bpi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bpi_cmd_sequencer
//  Description : Turns one high-level flash request (read, program, erase,
//                unlock, read status, clear status) into the P30 command
//                cycle sequence, issuing single bus cycles to the BPI bus
//                interface. Program/erase poll the status register with a
//                poll limit; a missing BUSY response aborts the request.
//  Ports       : CLK    system clock
//                RST_B  synchronous active-low reset
//                bus    bpi_cmd_sequencer_if.slave (request + bus signals)
//  Revision    : 1.0  initial release
// ============================================================================
module bpi_cmd_sequencer #(
    parameter logic [7:0]  BUSY_TIMEOUT = 8'd255,
    parameter logic [23:0] POLL_LIMIT   = 24'd4194304
) (
    input  logic               CLK,
    input  logic               RST_B,
    bpi_cmd_sequencer_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LATCH     = 4'd1;
    localparam logic [3:0] S_SETUP     = 4'd2;
    localparam logic [3:0] S_ISSUE     = 4'd3;
    localparam logic [3:0] S_WAIT_BUSY = 4'd4;
    localparam logic [3:0] S_WAIT_DONE = 4'd5;
    localparam logic [3:0] S_NEXT      = 4'd6;
    localparam logic [3:0] S_CHECK     = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;

    localparam logic [2:0] OP_READ    = 3'b001;
    localparam logic [2:0] OP_PROGRAM = 3'b010;
    localparam logic [2:0] OP_ERASE   = 3'b011;
    localparam logic [2:0] OP_UNLOCK  = 3'b100;
    localparam logic [2:0] OP_STATUS  = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_WRITE = 2'b01;
    localparam logic [1:0] BUS_READ  = 2'b10;

    // Program/erase step map: 0 setup cmd, 1 data/confirm, 2 read-status cmd,
    // 3 status poll read, 4 clear-status (error tail), 5 read-array (last).
    localparam logic [2:0] STEP_POLL  = 3'd3;
    localparam logic [2:0] STEP_CLEAR = 3'd4;
    localparam logic [2:0] STEP_ARRAY = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  state_q,    state_d;
    logic [2:0]  op_q,       op_d;
    logic [22:0] addr_q,     addr_d;
    logic [15:0] data_q,     data_d;
    logic [2:0]  step_q,     step_d;
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic        error_q,    error_d;
    logic [15:0] rd_data_q,  rd_data_d;
    logic [7:0]  sr_q,       sr_d;

    // ------------------------------------------------------------------
    // Current bus-cycle description, decoded from (op, step)
    // ------------------------------------------------------------------
    logic        cyc_write;   // 1 = write cycle, 0 = read cycle
    logic [15:0] cyc_data;    // command/data word for write cycles
    logic        cyc_last;    // final cycle of the sequence
    logic        cyc_poll;    // status poll read (result goes to SR, loops)
    logic        cyc_rd;      // read result goes to RD_DATA
    logic        cyc_sr;      // read result also copied into SR

    logic        op_legal;
    logic        busy_expired;
    logic        sr_fail;

    always_comb begin
        cyc_write = 1'b1;
        cyc_data  = 16'h00FF;
        cyc_last  = 1'b0;
        cyc_poll  = 1'b0;
        cyc_rd    = 1'b0;
        cyc_sr    = 1'b0;
        case (op_q)
            OP_READ: begin
                if (step_q != 3'd0) begin
                    cyc_write = 1'b0;
                    cyc_data  = 16'h0000;
                    cyc_rd    = 1'b1;
                    cyc_last  = 1'b1;
                end
            end
            OP_PROGRAM, OP_ERASE: begin
                case (step_q)
                    3'd0: cyc_data = (op_q == OP_PROGRAM) ? 16'h0040 : 16'h0020;
                    3'd1: cyc_data = (op_q == OP_PROGRAM) ? data_q   : 16'h00D0;
                    3'd2: cyc_data = 16'h0070;
                    STEP_POLL: begin
                        cyc_write = 1'b0;
                        cyc_data  = 16'h0000;
                        cyc_poll  = 1'b1;
                    end
                    STEP_CLEAR: cyc_data = 16'h0050;
                    default:    cyc_last = 1'b1;
                endcase
            end
            OP_UNLOCK: begin
                case (step_q)
                    3'd0:    cyc_data = 16'h0060;
                    3'd1:    cyc_data = 16'h00D0;
                    default: cyc_last = 1'b1;
                endcase
            end
            OP_STATUS: begin
                case (step_q)
                    3'd0: cyc_data = 16'h0070;
                    3'd1: begin
                        cyc_write = 1'b0;
                        cyc_data  = 16'h0000;
                        cyc_rd    = 1'b1;
                        cyc_sr    = 1'b1;
                    end
                    default: cyc_last = 1'b1;
                endcase
            end
            OP_CLEAR: begin
                if (step_q == 3'd0) begin
                    cyc_data = 16'h0050;
                end else begin
                    cyc_last = 1'b1;
                end
            end
            default: cyc_last = 1'b1;
        endcase
    end

    assign op_legal = (op_q != 3'b000) && (op_q != 3'b111);

    // busy_cnt_q counts cycles since EXECUTE (1 in the first WAIT_BUSY
    // cycle), so DONE lands BUSY_TIMEOUT cycles after the EXECUTE pulse.
    assign busy_expired = ({1'b0, busy_cnt_q} + 9'd1) >= {1'b0, BUSY_TIMEOUT};

    // Program/VPP/erase-suspend-independent failure bits of the P30 SR.
    assign sr_fail = sr_q[5] | sr_q[4] | sr_q[3] | sr_q[1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.REQ) state_d = S_LATCH;
            S_LATCH:     state_d = op_legal ? S_SETUP : S_FINISH;
            S_SETUP:     state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.BPI_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (busy_expired) begin
                    state_d = S_FINISH;
                end
            end
            S_WAIT_DONE: if (!bus.BPI_BUSY) state_d = S_NEXT;
            S_NEXT: begin
                if (cyc_poll) begin
                    state_d = S_CHECK;
                end else if (cyc_last) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_CHECK:  state_d = S_SETUP;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.ACK          = (state_q == S_LATCH);
        bus.CTRL_BUSY    = (state_q != S_IDLE);
        bus.DONE         = (state_q == S_FINISH);
        bus.BPI_EXECUTE  = (state_q == S_ISSUE);
        bus.BPI_ADDR     = 23'd0;
        bus.BPI_CMD_DATA = 16'h0000;
        bus.BPI_OP       = BUS_IDLE;
        // Bus cycle fields are valid from SETUP until WAIT_DONE exits.
        if ((state_q == S_SETUP) || (state_q == S_ISSUE) ||
            (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
            bus.BPI_ADDR     = addr_q;
            bus.BPI_CMD_DATA = cyc_data;
            bus.BPI_OP       = cyc_write ? BUS_WRITE : BUS_READ;
        end
    end

    assign bus.ERROR   = error_q;
    assign bus.RD_DATA = rd_data_q;
    assign bus.SR      = sr_q;

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        busy_cnt_d = busy_cnt_q;
        error_d    = error_q;
        rd_data_d  = rd_data_q;
        sr_d       = sr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    op_d       = bus.REQ_OP;
                    addr_d     = bus.REQ_ADDR;
                    data_d     = bus.REQ_DATA;
                    error_d    = 1'b0;
                    step_d     = 3'd0;
                    poll_cnt_d = 24'd0;
                end
            end
            S_LATCH: begin
                if (!op_legal) error_d = 1'b0 | 1'b1;
            end
            S_ISSUE: busy_cnt_d = 8'd1;
            S_WAIT_BUSY: begin
                if (!bus.BPI_BUSY) begin
                    if (busy_expired) begin
                        error_d = 1'b1;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 8'd1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (bus.BPI_LOAD_DATA && !cyc_write) begin
                    if (cyc_rd) rd_data_d = bus.BPI_DATA_IN;
                    if (cyc_sr || cyc_poll) sr_d = bus.BPI_DATA_IN[7:0];
                end
            end
            S_NEXT: begin
                if (cyc_poll) begin
                    poll_cnt_d = (poll_cnt_q >= POLL_LIMIT) ? POLL_LIMIT
                                                            : poll_cnt_q + 24'd1;
                end else if (!cyc_last) begin
                    step_d = step_q + 3'd1;
                end
            end
            S_CHECK: begin
                // A ready status wins over the poll limit on the same read.
                if (sr_q[7]) begin
                    if (sr_fail) begin
                        error_d = 1'b1;
                        step_d  = STEP_CLEAR;
                    end else begin
                        step_d  = STEP_ARRAY;
                    end
                end else if (poll_cnt_q >= POLL_LIMIT) begin
                    error_d = 1'b1;
                    step_d  = STEP_ARRAY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            op_q       <= 3'd0;
            addr_q     <= 23'd0;
            data_q     <= 16'h0000;
            step_q     <= 3'd0;
            poll_cnt_q <= 24'd0;
            busy_cnt_q <= 8'd0;
            error_q    <= 1'b0;
            rd_data_q  <= 16'h0000;
            sr_q       <= 8'h00;
        end else begin
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            step_q     <= step_d;
            poll_cnt_q <= poll_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            error_q    <= error_d;
            rd_data_q  <= rd_data_d;
            sr_q       <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpi_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_bpi_cmd_sequencer
//  Description : Self-checking bench for bpi_cmd_sequencer. A negedge bus
//                model executes bus cycles, logs them and returns queued
//                read data; a sequence-level reference model predicts the
//                cycle list, RD_DATA, SR and ERROR for each request.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bpi_cmd_sequencer;

    localparam logic [7:0] BT = 8'd8;
    localparam int         PL = 4;

    logic CLK = 1'b0;
    logic RST_B = 1'b0;
    always #12.5 CLK = ~CLK;

    bpi_cmd_sequencer_if bus();

    bpi_cmd_sequencer #(
        .BUSY_TIMEOUT (BT),
        .POLL_LIMIT   (24'd4)
    ) dut (
        .CLK   (CLK),
        .RST_B (RST_B),
        .bus   (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [15:0] data;
    } cyc_t;

    cyc_t        log_q[$];
    cyc_t        exp_q[$];
    logic [15:0] rsp_q[$];
    int          rd_idx = 0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, exec_cnt = 0, exec_cyc = 0, done_cnt = 0, done_cyc = 0, ack_cnt = 0;
    int busy_viol = 0, stab_viol = 0;
    bit busy_never = 1'b0;
    int rem = 0;
    bit cur_rd = 1'b0;
    logic [22:0] p_addr = '0, h_addr = '0;
    logic [15:0] p_data = '0, h_data = '0;
    logic [1:0]  p_op = '0, h_op = '0;

    logic        exp_err = 1'b0;
    logic [15:0] exp_rd = 16'h0;
    logic [7:0]  exp_sr = 8'h0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus interface / flash model
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        cyc++;
        if (bus.ACK)  ack_cnt++;
        if (bus.DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!RST_B) begin
            bus.BPI_BUSY      = 1'b0;
            bus.BPI_LOAD_DATA = 1'b0;
            bus.BPI_DATA_IN   = 16'h0;
            rem = 0;
        end else begin
            bus.BPI_LOAD_DATA = 1'b0;
            if (bus.BPI_EXECUTE) begin
                if (bus.BPI_BUSY) busy_viol++;
                if (bus.BPI_ADDR !== p_addr || bus.BPI_CMD_DATA !== p_data || bus.BPI_OP !== p_op)
                    stab_viol++;
                if (bus.BPI_OP != 2'b01 && bus.BPI_OP != 2'b10) stab_viol++;
                log_q.push_back(cyc_t'{bus.BPI_OP == 2'b01, bus.BPI_ADDR,
                                       (bus.BPI_OP == 2'b01) ? bus.BPI_CMD_DATA : 16'h0});
                exec_cnt++;
                exec_cyc = cyc;
                h_addr = bus.BPI_ADDR; h_data = bus.BPI_CMD_DATA; h_op = bus.BPI_OP;
                if (!busy_never) begin
                    bus.BPI_BUSY = 1'b1;
                    rem    = int'($urandom_range(6, 3));
                    cur_rd = (bus.BPI_OP == 2'b10);
                end
            end else if (rem > 0) begin
                if (bus.BPI_ADDR !== h_addr || bus.BPI_CMD_DATA !== h_data || bus.BPI_OP !== h_op)
                    stab_viol++;
                rem--;
                if (rem == 1 && cur_rd) begin
                    bus.BPI_LOAD_DATA = 1'b1;
                    bus.BPI_DATA_IN   = (rd_idx < rsp_q.size()) ? rsp_q[rd_idx] : 16'h0;
                    rd_idx++;
                end
                if (rem == 0) bus.BPI_BUSY = 1'b0;
            end
        end
        p_addr = bus.BPI_ADDR;
        p_data = bus.BPI_CMD_DATA;
        p_op   = bus.BPI_OP;
    end

    // ------------------------------------------------------------------
    // Reference model: expected cycle list and results per request
    // ------------------------------------------------------------------
    function automatic logic [15:0] rsp_at(input int i);
        return (i < rsp_q.size()) ? rsp_q[i] : 16'h0;
    endfunction

    task automatic build_exp(input logic [2:0] op, input logic [22:0] a, input logic [15:0] d);
        logic [15:0] w;
        logic [7:0]  s;
        bit          ready;
        logic [15:0] old_rd;
        logic [7:0]  old_sr;
        cyc_t        first;
        old_rd = exp_rd;
        old_sr = exp_sr;
        ready  = 1'b0;
        s      = 8'h0;
        exp_q.delete();
        exp_err = 1'b0;
        case (op)
            3'd1: begin
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00FF});
                exp_q.push_back(cyc_t'{1'b0, a, 16'h0});
                exp_rd = rsp_at(0);
            end
            3'd2, 3'd3: begin
                exp_q.push_back(cyc_t'{1'b1, a, (op == 3'd2) ? 16'h0040 : 16'h0020});
                exp_q.push_back(cyc_t'{1'b1, a, (op == 3'd2) ? d : 16'h00D0});
                exp_q.push_back(cyc_t'{1'b1, a, 16'h0070});
                for (int i = 0; i < PL; i++) begin
                    exp_q.push_back(cyc_t'{1'b0, a, 16'h0});
                    w = rsp_at(i);
                    s = w[7:0];
                    exp_sr = s;
                    if (s[7]) begin
                        ready = 1'b1;
                        break;
                    end
                end
                if (!ready) begin
                    exp_err = 1'b1;
                end else if (s[5] | s[4] | s[3] | s[1]) begin
                    exp_err = 1'b1;
                    exp_q.push_back(cyc_t'{1'b1, a, 16'h0050});
                end
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00FF});
            end
            3'd4: begin
                exp_q.push_back(cyc_t'{1'b1, a, 16'h0060});
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00D0});
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00FF});
            end
            3'd5: begin
                exp_q.push_back(cyc_t'{1'b1, a, 16'h0070});
                exp_q.push_back(cyc_t'{1'b0, a, 16'h0});
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00FF});
                w = rsp_at(0);
                exp_rd = w;
                exp_sr = w[7:0];
            end
            3'd6: begin
                exp_q.push_back(cyc_t'{1'b1, a, 16'h0050});
                exp_q.push_back(cyc_t'{1'b1, a, 16'h00FF});
            end
            default: exp_err = 1'b1;
        endcase
        // With no BUSY response only the first cycle is ever issued.
        if (busy_never && exp_q.size() > 0) begin
            first = exp_q[0];
            exp_q.delete();
            exp_q.push_back(first);
            exp_err = 1'b1;
            exp_rd  = old_rd;
            exp_sr  = old_sr;
        end
    endtask

    // ------------------------------------------------------------------
    // One request, end to end
    // ------------------------------------------------------------------
    task automatic run_req(input logic [2:0] op, input logic [22:0] a,
                           input logic [15:0] d, input string tag);
        int a0, d0;
        bit got;
        got = 1'b0;
        build_exp(op, a, d);
        log_q.delete();
        rd_idx = 0;
        @(negedge CLK);
        a0 = ack_cnt;
        d0 = done_cnt;
        bus.REQ = 1'b1; bus.REQ_OP = op; bus.REQ_ADDR = a; bus.REQ_DATA = d;
        @(negedge CLK);
        bus.REQ = 1'b0;
        bus.REQ_OP = 3'($urandom); bus.REQ_ADDR = 23'($urandom); bus.REQ_DATA = 16'($urandom);
        check_val({tag, "_ack"}, bus.ACK, 1);
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (i == 2) bus.REQ = 1'b1;   // stray request while busy: must be ignored
            if (i == 3) bus.REQ = 1'b0;
            if (bus.DONE) begin
                got = 1'b1;
                break;
            end
        end
        bus.REQ = 1'b0;
        check_val({tag, "_done_seen"}, got, 1);
        check_val({tag, "_error"}, bus.ERROR, exp_err);
        check_val({tag, "_rd_data"}, bus.RD_DATA, exp_rd);
        check_val({tag, "_sr"}, bus.SR, exp_sr);
        @(negedge CLK);
        @(negedge CLK);
        check_val({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_val({tag, "_ack_pulses"}, ack_cnt - a0, 1);
        check_val({tag, "_idle_busy"}, bus.CTRL_BUSY, 0);
        check_val({tag, "_ncycles"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_val($sformatf("%s_cycle%0d", tag, i), log_q[i], exp_q[i]);
        if (busy_never)
            check_val({tag, "_timeout_lat"}, done_cyc - exec_cyc, BT);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ack"},   bus.ACK, 0);
        check_val({tag, "_cbusy"}, bus.CTRL_BUSY, 0);
        check_val({tag, "_done"},  bus.DONE, 0);
        check_val({tag, "_err"},   bus.ERROR, 0);
        check_val({tag, "_rd"},    bus.RD_DATA, 0);
        check_val({tag, "_sr"},    bus.SR, 0);
        check_val({tag, "_addr"},  bus.BPI_ADDR, 0);
        check_val({tag, "_cdata"}, bus.BPI_CMD_DATA, 0);
        check_val({tag, "_op"},    bus.BPI_OP, 0);
        check_val({tag, "_exec"},  bus.BPI_EXECUTE, 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int e0, e1, r, nr;
        logic [2:0] op;
        bus.REQ = 1'b0; bus.REQ_OP = 3'd0; bus.REQ_ADDR = 23'd0; bus.REQ_DATA = 16'd0;
        RST_B = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_B = 1'b1;
        repeat (2) @(negedge CLK);

        rsp_q = '{16'hBEEF};
        run_req(3'b001, 23'h012345, 16'h0000, "read");

        rsp_q = '{16'h0000, 16'h0000, 16'h0080};
        run_req(3'b010, 23'h000100, 16'hA5A5, "program");

        rsp_q = '{16'h0000, 16'h00A0};
        run_req(3'b011, 23'h040000, 16'h0000, "erase_fail");

        rsp_q.delete();
        run_req(3'b010, 23'h000222, 16'h1234, "poll_timeout");

        busy_never = 1'b1;
        rsp_q = '{16'h5555};
        run_req(3'b001, 23'h007777, 16'h0000, "busy_never");
        busy_never = 1'b0;

        run_req(3'b111, 23'h000001, 16'h0000, "illegal7");
        run_req(3'b000, 23'h000002, 16'h0000, "illegal0");
        check_val("illegal_no_exec", log_q.size(), 0);

        rsp_q = '{16'h12C3};
        run_req(3'b101, 23'h000010, 16'h0000, "status");
        run_req(3'b100, 23'h020000, 16'h0000, "unlock");
        run_req(3'b110, 23'h000000, 16'h0000, "clear");

        // Reset in the middle of a program poll.
        rsp_q.delete();
        log_q.delete();
        rd_idx = 0;
        e0 = exec_cnt;
        @(negedge CLK);
        bus.REQ = 1'b1; bus.REQ_OP = 3'b010; bus.REQ_ADDR = 23'h000333; bus.REQ_DATA = 16'hCAFE;
        @(negedge CLK);
        bus.REQ = 1'b0;
        for (int i = 0; i < 300 && exec_cnt < e0 + 5; i++) @(negedge CLK);
        check_val("midreset_reached_poll", exec_cnt >= e0 + 5, 1);
        RST_B = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midreset");
        e1 = exec_cnt;
        @(negedge CLK);
        RST_B = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("midreset_no_exec", exec_cnt, e1);
        exp_rd = 16'h0; exp_sr = 8'h0; exp_err = 1'b0;

        // Randomized requests
        for (int n = 0; n < 30; n++) begin
            r  = int'($urandom_range(15, 0));
            op = (r < 14) ? 3'(1 + r % 6) : ((r == 14) ? 3'd0 : 3'd7);
            rsp_q.delete();
            if (op == 3'd1 || op == 3'd5) begin
                rsp_q.push_back(16'($urandom));
            end else if (op == 3'd2 || op == 3'd3) begin
                nr = int'($urandom_range(4, 0));
                for (int k = 0; k < nr; k++) rsp_q.push_back(16'($urandom) & 16'hFF7F);
                if (nr < 4) begin
                    if ($urandom_range(1, 0) == 0)
                        rsp_q.push_back((16'($urandom) | 16'h0080) & 16'hFFC5);
                    else
                        rsp_q.push_back(16'($urandom) | 16'h0080);
                end
            end
            run_req(op, 23'($urandom), 16'($urandom), $sformatf("rnd%0d", n));
        end

        check_val("exec_while_busy", busy_viol, 0);
        check_val("bus_fields_stable", stab_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
